// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, node-ID type and injector state encoding.
package noc_pkg;

    localparam int unsigned ID_W        = 2;
    localparam int unsigned FLIT_W_DEF  = 16;

    // Field positions for the default 16-bit flit: dest | src | payload.
    localparam int unsigned DEST_MSB    = FLIT_W_DEF - 1;
    localparam int unsigned DEST_LSB    = FLIT_W_DEF - 2;
    localparam int unsigned SRC_MSB     = FLIT_W_DEF - 3;
    localparam int unsigned SRC_LSB     = FLIT_W_DEF - 4;
    localparam int unsigned PAYLOAD_MSB = FLIT_W_DEF - 5;

    typedef logic [ID_W-1:0] node_id_t;

    typedef enum logic [1:0] {
        InjIdle    = 2'd0,
        InjSend    = 2'd1,
        InjBlocked = 2'd2,
        InjPaced   = 2'd3
    } inj_state_e;

endpackage

// File: rtl/noc_inj_fifo.sv
// Injection queue: synchronous FIFO with occupancy count and same-cycle push+pop.
module noc_inj_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/noc_local_injector.sv
// Local NoC injector: buffers host flits, stamps dest/src IDs, drives the router write port.
// Optional statistics counters are enabled with the NOC_INJ_STATS_EN macro.
module noc_local_injector
    import noc_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter node_id_t    NODE_ID = 2'b00,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned QADDR   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [1:0]       req_dest,
    input  logic [WIDTH-5:0] req_payload,
    output logic             req_ready,
    input  logic             full,
    input  logic             almost_full,
    output logic             write,
    output logic [WIDTH-1:0] dataIn,
    output logic             busy,
    output logic [15:0]      tx_flits,
    output logic [15:0]      stall_cycles
);

    localparam logic [1:0] ST_IDLE    = InjIdle;
    localparam logic [1:0] ST_SEND    = InjSend;
    localparam logic [1:0] ST_BLOCKED = InjBlocked;
    localparam logic [1:0] ST_PACED   = InjPaced;

    logic [QADDR:0]   count;
    logic [WIDTH-1:0] head, push_flit, data_q;
    logic             push, issue, nonempty;
    logic [1:0]       state_q, state_d;

    // The registered write strobe is exactly the SEND state.
    assign write     = (state_q == ST_SEND);
    assign nonempty  = (count != '0);
    assign req_ready = !reset && (count < (QADDR + 1)'(QDEPTH));
    assign push      = req_valid && req_ready;
    assign push_flit = {req_dest, NODE_ID, req_payload};
    assign issue     = !reset && nonempty && !full && !(almost_full && write);

    always_comb begin
        state_d = ST_IDLE;
        if (issue) begin
            state_d = ST_SEND;
        end else if (nonempty && full) begin
            state_d = ST_BLOCKED;
        end else if (nonempty && almost_full && write) begin
            state_d = ST_PACED;
        end
    end

    noc_inj_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (QDEPTH),
        .AW    (QADDR)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (issue),
        .wdata_i (push_flit),
        .rdata_o (head),
        .count_o (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                data_q <= head;
            end
        end
    end

    assign dataIn = data_q;
    assign busy   = nonempty || write;

`ifdef NOC_INJ_STATS_EN
    logic [15:0] tx_q, stall_q;
    logic        stalled;

    assign stalled = (state_d == ST_BLOCKED) || (state_d == ST_PACED);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q    <= '0;
            stall_q <= '0;
        end else begin
            if (issue) begin
                tx_q <= tx_q + 16'd1;
            end
            if (stalled && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign tx_flits     = tx_q;
    assign stall_cycles = stall_q;
`else
    assign tx_flits     = 16'd0;
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_noc_local_injector.sv
// Scoreboard bench for noc_local_injector: queue-level reference model plus negedge monitor.
module tb_noc_local_injector;

`ifdef NOC_INJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_dest;
    logic [11:0] req_payload;
    logic        req_ready;
    logic        full;
    logic        almost_full;
    logic        write;
    logic [15:0] dataIn;
    logic        busy;
    logic [15:0] tx_flits;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Reference model state
    logic [15:0] m_q[$];
    logic [15:0] exp_q[$];
    bit          m_w;
    int          m_tx;
    int          m_stall;

    always #5 clk = ~clk;

    noc_local_injector #(
        .WIDTH   (16),
        .NODE_ID (2'b01),
        .QDEPTH  (4),
        .QADDR   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_dest     (req_dest),
        .req_payload  (req_payload),
        .req_ready    (req_ready),
        .full         (full),
        .almost_full  (almost_full),
        .write        (write),
        .dataIn       (dataIn),
        .busy         (busy),
        .tx_flits     (tx_flits),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one decision per clock from the queue contents and the last strobe.
    always @(posedge clk) begin
        bit rdy, iss;
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            m_w     = 1'b0;
            m_tx    = 0;
            m_stall = 0;
        end else begin
            rdy = (m_q.size() < 4);
            iss = (m_q.size() != 0) && !full && !(almost_full && m_w);
            if (iss) begin
                exp_q.push_back(m_q.pop_front());
                m_tx++;
            end else if (m_q.size() != 0 && m_stall < 65535) begin
                m_stall++;
            end
            if (req_valid && rdy) begin
                m_q.push_back({req_dest, 2'b01, req_payload});
            end
            m_w = iss;
        end
    end

    // Monitor: pops the scoreboard on every DUT write and checks status outputs.
    always @(negedge clk) begin
        if (started) begin
            if (write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_write: got write with data %h expected no write", dataIn);
                end else begin
                    chk("sb_dataIn", {16'd0, dataIn}, {16'd0, exp_q.pop_front()});
                end
            end
            chk("write", {31'd0, write}, {31'd0, m_w});
            chk("req_ready", {31'd0, req_ready}, {31'd0, (!reset && m_q.size() < 4)});
            chk("busy", {31'd0, busy}, {31'd0, (m_q.size() != 0 || m_w)});
            chk("tx_flits", {16'd0, tx_flits}, STATS ? (m_tx % 65536) : 0);
            chk("stall_cycles", {16'd0, stall_cycles}, STATS ? m_stall : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] d, input logic [11:0] p);
        req_valid   = 1'b1;
        req_dest    = d;
        req_payload = p;
        step();
        req_valid   = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_dest    = 2'd0;
        req_payload = 12'd0;
        full        = 1'b0;
        almost_full = 1'b0;
        step();
        started = 1'b1;
        step();
        reset = 1'b0;

        // Single flit, no backpressure: one-cycle latency
        push_one(2'b11, 12'hABC);
        step();
        chk("lat_write", {31'd0, write}, 32'd1);
        chk("lat_data", {16'd0, dataIn}, 32'h0000DABC);
        chk("lat_tx", {16'd0, tx_flits}, STATS ? 32'd1 : 32'd0);
        step();
        step();

        // Fill under full, then release
        full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_one(2'(i), 12'($urandom));
        end
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        chk("full_write", {31'd0, write}, 32'd0);
        step();
        step();
        full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("release_write", {31'd0, write}, 32'd1);
        end
        step();

        // almost_full pacing: 1,0,1,0,1
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_one(2'(3 - i), 12'($urandom));
        end
        full        = 1'b0;
        almost_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("paced_write", {31'd0, write}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        almost_full = 1'b0;
        step();

        // Reset with flits queued and a strobe in flight
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_one(2'(i), 12'($urandom));
        end
        full = 1'b0;
        step();
        chk("pre_rst_write", {31'd0, write}, 32'd1);
        reset = 1'b1;
        step();
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx", {16'd0, tx_flits}, 32'd0);
        chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
        reset = 1'b0;
        push_one(2'b10, 12'h123);
        step();
        chk("post_rst_write", {31'd0, write}, 32'd1);
        chk("post_rst_data", {16'd0, dataIn}, 32'h00009123);

        // Randomized traffic with backpressure and occasional resets
        for (int n = 0; n < 3000; n++) begin
            req_valid   = ($urandom_range(0, 3) != 0);
            req_dest    = 2'($urandom);
            req_payload = 12'($urandom);
            full        = ($urandom_range(0, 7) == 0);
            almost_full = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            step();
        end

        // Drain with a bounded wait
        req_valid   = 1'b0;
        full        = 1'b0;
        almost_full = 1'b0;
        reset       = 1'b0;
        for (int n = 0; n < 20 && (busy !== 1'b0); n++) begin
            step();
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_local_injector.md
# noc_local_injector

Transmit-side network interface for one NoC node. It accepts flits from a local host over a valid/ready handshake and buffers them in a small FIFO. It stamps destination and source IDs into each flit and drives the router's local write port (write/dataIn), honouring the router's full/almost_full backpressure. One instance sits between each host engine and its router's local port.

## Interface
Parameters:
- WIDTH, 16, flit width in bits.
- NODE_ID, 2'b00, this node's router ID, stamped as source.
- QDEPTH, 4, injection queue entries (power of two, ≥2).
- QADDR, 2, log2(QDEPTH).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- req_valid  in  1  host flit valid.
- req_dest  in  2  destination router ID.
- req_payload  in  WIDTH-4  payload.
- req_ready  out  1  host may transfer this cycle.
- full  in  1  router local FIFO full.
- almost_full  in  1  router local FIFO almost full.
- write  out  1  write strobe to router local port.
- dataIn  out  WIDTH  flit to router local port.
- busy  out  1  queue non-empty or write asserted.
- tx_flits  out  16  flits injected (stats, see Configuration).
- stall_cycles  out  16  cycles a flit waited on backpressure (stats).

## Operation
- Flit format: [WIDTH-1:WIDTH-2]=dest, [WIDTH-3:WIDTH-4]=NODE_ID, [WIDTH-5:0]=payload. Assembled at push time.
- Push: req_valid && req_ready. req_ready = !reset && (count < QDEPTH), combinational from count only.
- Issue decision each posedge: issue = count≠0 && !full && !(almost_full && write). "write" means the current registered strobe. Under almost_full the block therefore writes at most every other cycle.
- On issue: write<=1, dataIn<=head, pop. Otherwise write<=0 and dataIn holds its last value.
- Simultaneous push and pop: count unchanged, order preserved. Pointers wrap modulo QDEPTH.
- FSM (observability and stats; issue equation is authoritative):
  - IDLE: count==0.
  - SEND: issued this cycle.
  - BLOCKED: count≠0 && full.
  - PACED: count≠0 && almost_full && write && !full.
  - Any state → IDLE when count reaches 0 with no issue. Any state → SEND on issue.
- busy = (count≠0) || write.

## Timing
- Reset values: write=0, dataIn=0, count=0, pointers=0, state=IDLE, tx_flits=0, stall_cycles=0. req_ready=0 while reset is high and 1 in the first cycle after.
- Latency: a flit pushed at edge N into an empty queue with full=almost_full=0 gives write=1 with that flit during cycle N+1 (decision at edge N+1). Total 1 cycle from push edge.
- Throughput: 1 flit/cycle without backpressure; 1 per 2 cycles while almost_full=1; 0 while full=1.
- full is sampled at the decision edge. A strobe already registered is not retracted. The router's almost_full margin absorbs it.
- Reset mid-operation: queued flits are discarded and write drops at the reset edge. No partial flit is emitted.

## Configuration
- NOC_INJ_STATS_EN defined:
  - tx_flits increments on each issue and wraps at 2^16.
  - stall_cycles increments each cycle in BLOCKED or PACED without an issue, and saturates at 16'hFFFF.
- Not defined: both outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Shared package noc_pkg holds:
  - flit field position constants (DEST_MSB/LSB, SRC_MSB/LSB, PAYLOAD_MSB).
  - the node-ID typedef (2-bit).
  - the injector state enum.
- One sub-module: noc_inj_fifo (synchronous FIFO, QDEPTH×WIDTH, push/pop/count, same-cycle push+pop). The FSM, issue logic, output registers and stats stay in the top.

## Test plan
- NODE_ID=2'b01, push dest=2'b11, payload=12'hABC with full=almost_full=0 → next cycle write=1, dataIn=16'hDABC; tx_flits=1.
- Push 4 flits back-to-back with full=1 → req_ready=0 after 4th; write stays 0; stall_cycles counts. Release full → 4 consecutive writes in FIFO order.
- almost_full=1, 3 flits queued → writes on alternate cycles (1,0,1,0,1); data order preserved.
- Queue full (count=4) while issuing each cycle → req_ready=0 that cycle. With count=3 a simultaneous push+pop keeps count=3 and drops no flit.
- Assert reset with 3 flits queued and write=1 → next cycle write=0, busy=0, counters 0; a post-reset push is the first flit emitted.
- Build without NOC_INJ_STATS_EN, rerun scenario 1 → identical write/dataIn; tx_flits=stall_cycles=0.
